// File: rtl/mine_placer.sv
// Mine placement sequencer: draws unique mine cells from an LFSR stream, falls back to a
// linear scan if the stream stalls, then sweeps the board writing mine markers / counts.
module mine_placer #(
  parameter int unsigned ROWS          = 9,
  parameter int unsigned COLS          = 9,
  parameter int unsigned MINES         = 9,
  parameter int unsigned ATTEMPT_LIMIT = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] safe_idx,
  input  logic [7:0] rnd,
  output logic       busy,
  output logic       done,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [3:0] wr_data,
  output logic [3:0] placed
);

  localparam int unsigned CELLS   = ROWS * COLS;
  localparam int          NumRows = int'(ROWS);
  localparam int          NumCols = int'(COLS);
  localparam int unsigned AttW    = (ATTEMPT_LIMIT > 2) ? $clog2(ATTEMPT_LIMIT) : 1;
  localparam int unsigned RowW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW    = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [6:0]      LastCell = 7'(CELLS - 1);
  localparam logic [3:0]      MinesW   = 4'(MINES);
  localparam logic [AttW-1:0] AttLast  = AttW'(ATTEMPT_LIMIT - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(ROWS - 1);
  localparam logic [ColW-1:0] ColLast  = ColW'(COLS - 1);
  localparam logic [3:0]      MineMark = 4'hF;

  if (MINES < 1 || MINES >= CELLS || MINES > 15) begin : gen_bad_mines
    $error("mine_placer: MINES must lie in 1..CELLS-1 and fit the 4-bit placed count");
  end
  if (CELLS > 128) begin : gen_bad_board
    $error("mine_placer: board must fit a 7-bit cell index");
  end
  if (ATTEMPT_LIMIT < 2) begin : gen_bad_limit
    $error("mine_placer: ATTEMPT_LIMIT must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StPlace,
    StFallback,
    StCount,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CELLS-1:0] bitmap_q, bitmap_d;
  logic [3:0]       placed_q, placed_d;
  logic [AttW-1:0]  attempt_q, attempt_d;
  logic [6:0]       ptr_q, ptr_d;
  logic [6:0]       safe_q, safe_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [ColW-1:0]  col_q, col_d;
  logic             wr_en_q, wr_en_d;
  logic [6:0]       wr_addr_q, wr_addr_d;
  logic [3:0]       wr_data_q, wr_data_d;
  logic             done_q, done_d;

  // Bitmap padded to the full 7-bit index space so any candidate can index it safely.
  logic [127:0] map_cur, map_nxt;
  logic [6:0]   cand, sweep_idx;
  logic         cand_ok, fb_ok, last_mine;

  logic unused_rnd_msb;
  assign unused_rnd_msb = rnd[7];

  function automatic logic [3:0] neighbours(input logic [127:0] map, input int row,
                                            input int col);
    logic [3:0] n;
    int         rr, cc;
    n = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = row + dr;
        cc = col + dc;
        if ((dr != 0 || dc != 0) && rr >= 0 && rr < NumRows && cc >= 0 && cc < NumCols) begin
          if (map[7'(rr * NumCols + cc)]) n = n + 4'd1;
        end
      end
    end
    return n;
  endfunction

  always_comb begin
    map_cur              = '0;
    map_cur[CELLS-1:0]   = bitmap_q;
    map_nxt              = map_cur;
    state_d              = state_q;
    placed_d             = placed_q;
    attempt_d            = attempt_q;
    ptr_d                = ptr_q;
    safe_d               = safe_q;
    row_d                = row_q;
    col_d                = col_q;
    cand                 = rnd[6:0];
    cand_ok              = (cand <= LastCell) && !map_cur[cand] && (cand != safe_q);
    fb_ok                = !map_cur[ptr_q] && (ptr_q != safe_q);
    last_mine            = (placed_q == MinesW - 4'd1);

    case (state_q)
      StIdle: begin
        if (start) begin
          map_nxt   = '0;
          placed_d  = '0;
          attempt_d = '0;
          safe_d    = safe_idx;
          state_d   = StPlace;
        end
      end
      StPlace: begin
        attempt_d = attempt_q + 1'b1;
        if (cand_ok) begin
          map_nxt[cand] = 1'b1;
          placed_d      = placed_q + 4'd1;
        end
        if (cand_ok && last_mine) begin
          state_d = StCount;
          row_d   = '0;
          col_d   = '0;
        end else if (attempt_q == AttLast) begin
          state_d = StFallback;
          ptr_d   = '0;
        end
      end
      StFallback: begin
        ptr_d = ptr_q + 7'd1;
        if (fb_ok) begin
          map_nxt[ptr_q] = 1'b1;
          placed_d       = placed_q + 4'd1;
          if (last_mine) begin
            state_d = StCount;
            row_d   = '0;
            col_d   = '0;
          end
        end
      end
      StCount: begin
        if (row_q == RowLast && col_q == ColLast) begin
          state_d = StDone;
        end else if (col_q == ColLast) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    bitmap_d = map_nxt[CELLS-1:0];

    // Write port is registered: compute the value for the cell being entered on this edge,
    // using the post-edge bitmap so the final mine of the run is already visible.
    sweep_idx = 7'(int'(row_d) * NumCols + int'(col_d));
    wr_en_d   = (state_d == StCount);
    wr_addr_d = wr_en_d ? sweep_idx : '0;
    wr_data_d = '0;
    if (wr_en_d) begin
      wr_data_d = map_nxt[sweep_idx] ? MineMark : neighbours(map_nxt, int'(row_d), int'(col_d));
    end
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      bitmap_q  <= '0;
      placed_q  <= '0;
      attempt_q <= '0;
      ptr_q     <= '0;
      safe_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitmap_q  <= bitmap_d;
      placed_q  <= placed_d;
      attempt_q <= attempt_d;
      ptr_q     <= ptr_d;
      safe_q    <= safe_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == StPlace) || (state_q == StFallback) || (state_q == StCount);
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign placed  = placed_q;

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: a game-level model predicts the mine set and the full write stream,
// and a negedge compare process checks every output against it each cycle.
module tb_mine_placer;

  localparam int ROWS  = 9;
  localparam int COLS  = 9;
  localparam int CELLS = 81;
  localparam int MINES = 9;
  localparam int LIMIT = 1024;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [6:0] safe_idx;
  logic [7:0] rnd;
  logic       busy, done, wr_en;
  logic [6:0] wr_addr;
  logic [3:0] wr_data, placed;

  mine_placer dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .safe_idx(safe_idx),
    .rnd     (rnd),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .placed  (placed)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Model state
  logic [7:0] seq[$];
  logic [7:0] fill = 8'd0;
  bit         m_mine[CELLS];
  int         hist[$];
  logic [3:0] dut_board[128];

  // Expected outputs for the current cycle
  bit         chk_on = 1'b0;
  logic       exp_busy, exp_done, exp_wr_en, exp_chk_wr;
  logic [6:0] exp_addr;
  logic [3:0] exp_data, exp_placed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("wr_en", 32'(wr_en), 32'(exp_wr_en));
      chk("placed", 32'(placed), 32'(exp_placed));
      if (exp_chk_wr) begin
        chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
        chk("wr_data", 32'(wr_data), 32'(exp_data));
      end
    end
  end

  always @(negedge clock) begin
    if (wr_en === 1'b1) dut_board[wr_addr] = wr_data;
  end

  function automatic logic [7:0] rnd_at(input int j);
    return (j < seq.size()) ? seq[j] : fill;
  endfunction

  // Mine set and per-cycle placed count that the rules imply for the current rnd stream.
  task automatic plan(input int safe);
    int count, c;
    count = 0;
    hist.delete();
    for (int i = 0; i < CELLS; i++) m_mine[i] = 1'b0;
    for (int i = 0; i < LIMIT && count < MINES; i++) begin
      c = int'(rnd_at(i)) % 128;
      if (c < CELLS && !m_mine[c] && c != safe) begin
        m_mine[c] = 1'b1;
        count++;
      end
      hist.push_back(count);
    end
    for (int p = 0; p < CELLS && count < MINES; p++) begin
      if (!m_mine[p] && p != safe) begin
        m_mine[p] = 1'b1;
        count++;
      end
      hist.push_back(count);
    end
  endtask

  function automatic int model_cell(input int idx);
    int r, c, n;
    r = idx / COLS;
    c = idx % COLS;
    n = 0;
    if (m_mine[idx]) return 15;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS && c + dc >= 0 &&
            c + dc < COLS) begin
          n += int'(m_mine[(r + dr) * COLS + c + dc]);
        end
      end
    end
    return n;
  endfunction

  task automatic set_exp(input logic b, input logic d, input logic w, input logic cw,
                         input int a, input int dt, input int pl);
    exp_busy   = b;
    exp_done   = d;
    exp_wr_en  = w;
    exp_chk_wr = cw;
    exp_addr   = 7'(a);
    exp_data   = 4'(dt);
    exp_placed = 4'(pl);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full game; reset_at >= 0 aborts the sweep with reset while that address is written.
  task automatic run_game(input int safe, input bit mid_start, input int reset_at);
    int p;
    plan(safe);
    p = hist.size();
    for (int i = 0; i < 128; i++) dut_board[i] = 4'hE;
    safe_idx = 7'(safe);
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < p; j++) begin
      set_exp(1, 0, 0, 0, 0, 0, (j == 0) ? 0 : hist[j-1]);
      rnd = rnd_at(j);
      tick();
    end
    for (int k = 0; k < CELLS; k++) begin
      set_exp(1, 0, 1, 1, k, model_cell(k), MINES);
      start = mid_start && (k == 30);
      if (k == reset_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        set_exp(0, 0, 0, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
          set_exp(0, 0, 0, 0, 0, 0, 0);
          tick();
        end
        return;
      end
      tick();
    end
    start = 1'b0;
    set_exp(0, 1, 0, 0, 0, 0, MINES);
    tick();
    set_exp(0, 0, 0, 0, 0, 0, MINES);
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b1;
    safe_idx = 7'd0;
    rnd      = 8'd0;

    // Reset held with start asserted: outputs stay 0, block stays idle
    tick();
    set_exp(0, 0, 0, 1, 0, 0, 0);
    chk_on = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    set_exp(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Rejection of duplicate, out-of-range and safe candidates
    seq = '{8'd3, 8'd3, 8'h51, 8'hD1, 8'd40, 8'h80, 8'd7, 8'd11, 8'd12, 8'd13, 8'd14,
            8'd15, 8'd16};
    plan(40);
    chk("rej_h0", 32'(hist[0]), 1);
    chk("rej_h1", 32'(hist[1]), 1);
    chk("rej_h2", 32'(hist[2]), 1);
    chk("rej_h3", 32'(hist[3]), 1);
    chk("rej_h4", 32'(hist[4]), 1);
    chk("rej_h5", 32'(hist[5]), 2);
    chk("rej_h6", 32'(hist[6]), 3);
    chk("rej_len", 32'(hist.size()), 13);
    run_game(40, 1'b0, -1);

    // Neighbour counts, with start pulsed mid-sweep
    seq = '{8'd0, 8'd1, 8'd9, 8'd44, 8'd46, 8'd48, 8'd60, 8'd62, 8'd64};
    run_game(80, 1'b1, -1);
    chk("nb_c10", 32'(dut_board[10]), 3);
    chk("nb_c0", 32'(dut_board[0]), 15);
    chk("nb_c18", 32'(dut_board[18]), 1);
    chk("nb_c80", 32'(dut_board[80]), 0);
    chk("nb_c8_edge", 32'(dut_board[8]), 0);
    chk("nb_c2", 32'(dut_board[2]), 1);

    // Reset in the middle of the sweep
    seq = '{8'd3, 8'd3, 8'h51, 8'hD1, 8'd40, 8'h80, 8'd7, 8'd11, 8'd12, 8'd13, 8'd14,
            8'd15, 8'd16};
    run_game(40, 1'b0, 40);

    // Stuck LFSR: fallback placement after the attempt budget
    seq.delete();
    fill = 8'd0;
    plan(1);
    chk("stuck_len", 32'(hist.size()), 1034);
    run_game(1, 1'b0, -1);
    for (int i = 0; i < CELLS; i++) begin
      chk("stuck_mine", 32'(dut_board[i] == 4'hF), 32'(i == 0 || (i >= 2 && i <= 9)));
    end

    chk_on = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
